matrix_frame_ctrl: RTL and testbench
====================================

Name: matrix_frame_ctrl

Overview:
- Scan controller and double-buffered frame store for the 8x8 red/green LED matrix.
- Game and result-screen logic write rows into a back buffer, then request a swap. The controller applies the swap only at a frame boundary, so no frame is ever displayed half-updated.
- Owns row multiplexing, inter-row blanking and the matrix_scanout / matrix_segout_r / matrix_segout_g pins.

Parameters:
- ROW_DWELL, 8192, clk cycles per row. Legal range >= 4.
- BLANK_CYCLES, 64, cycles at the start of each row during which all matrix outputs are 0 (anti-ghosting). Must be < ROW_DWELL.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- wr_en  in  1  write strobe for a back-buffer row
- wr_row  in  3  row index being written
- wr_r  in  8  red pixels, bit7 = column 0
- wr_g  in  8  green pixels, bit7 = column 0
- swap_req  in  1  request a front/back swap at the next frame boundary
- swap_ack  out  1  one-cycle pulse when the swap is applied
- wr_drop  out  1  one-cycle pulse when a write is discarded
- frame_start  out  1  one-cycle pulse at the start of row 0
- matrix_scanout  out  8  one-hot row select
- matrix_segout_r  out  8  red column data
- matrix_segout_g  out  8  green column data

Behaviour:
- Storage:
  - Two banks (0 and 1), each 8 rows x 16 bits.
  - disp_sel selects the front (displayed) bank; the back bank is ~disp_sel.
- Reset (async, reset=0):
  - Both banks cleared; disp_sel=0; pending=0.
  - Counters: row=0, dwell=0.
  - All outputs 0.
- Scan counters:
  - dwell counts 0..ROW_DWELL-1, then wraps to 0 and row increments; row wraps 7 -> 0.
  - Frame period is exactly 8*ROW_DWELL cycles.
- Outputs are registered and reflect the counter state of the previous cycle (1-cycle latency):
  - When dwell < BLANK_CYCLES: scanout=0, segout_r=0, segout_g=0.
  - Otherwise: scanout = 8'b1 << row, and segout_r / segout_g = front bank row data.
  - frame_start = registered (row==0 && dwell==0). It is therefore 1 in the first cycle after reset release, then once every 8*ROW_DWELL cycles.
- Writes:
  - When wr_en=1 and pending=0, {wr_r, wr_g} is written to back[wr_row] at the clk edge. No backpressure.
  - When wr_en=1 and pending=1, the write is dropped and wr_drop pulses for one cycle.
- Swap handshake:
  - swap_req=1 with pending=0 sets pending on the next edge.
  - swap_req while pending=1 is ignored (requests do not queue).
  - Frame boundary is the cycle with row==7 and dwell==ROW_DWELL-1. If pending=1 at that edge: disp_sel toggles, pending clears, and swap_ack pulses in the same output cycle as the following frame_start.
  - swap_req asserted in the boundary cycle itself with pending=0 is latched and applied at the next boundary, not the current one.
- Simultaneous events:
  - wr_en and swap_req in the same cycle with pending=0: the write is accepted into the current back bank, then pending sets.
  - wr_en in the boundary cycle with pending=1: the write is dropped.
- Reset mid-frame: all state returns immediately to the reset values. A pending swap is lost, and no swap_ack is issued for it.
- Front-bank contents are never modified by the write port.

Optional Feature:
- Macro: MATRIX_DIM_EN.
- Defined:
  - Adds input brightness [2:0].
  - Lit window L = ROW_DWELL - BLANK_CYCLES.
  - In the lit window, segout_r and segout_g are forced to 0 when (dwell - BLANK_CYCLES) >= ((brightness+1)*L) >> 3. scanout is unaffected.
  - brightness=7 gives full on-time.
  - brightness is sampled once per row, at dwell==0.
- Undefined: no brightness port; the full lit window is always driven.

Test Plan:
All scenarios use ROW_DWELL=16, BLANK_CYCLES=2.
- Reset release -> first cycle: frame_start=1, all matrix outputs 0. frame_start repeats every 128 cycles; scanout = 0x01, 0x02, ... 0x80, each lit for 14 of 16 cycles.
- Write back rows 0..7 with r=8'h81, g=8'h3C, no swap -> segout stays 0 for 3 full frames.
- Same writes, then swap_req pulse -> swap_ack coincides with the next frame_start. During row 0 lit cycles: segout_r=8'h81, segout_g=8'h3C.
- swap_req at cycle 10 of a frame, then wr_en (row 2, r=8'hFF) at cycle 20 -> wr_drop pulses at cycle 20; after the swap, row 2 does not show 8'hFF.
- swap_req exactly in the boundary cycle -> no swap_ack at the immediate frame_start; swap_ack at the following one (128 cycles later).
- Assert reset=0 while pending=1 mid-row 5 -> outputs go to 0 asynchronously; after release there is no swap_ack and both banks read 0.

Source files
------------

// File: rtl/matrix_frame_ctrl.sv
// Row-scan controller and double-buffered frame store for the 8x8 red/green LED matrix.
// Optional MATRIX_DIM_EN macro adds a per-row brightness (on-time) control.
module matrix_frame_ctrl #(
    parameter int ROW_DWELL    = 8192,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_r,
    input  logic [7:0] wr_g,
    input  logic       swap_req,
`ifdef MATRIX_DIM_EN
    input  logic [2:0] brightness,
`endif
    output logic       swap_ack,
    output logic       wr_drop,
    output logic       frame_start,
    output logic [7:0] matrix_scanout,
    output logic [7:0] matrix_segout_r,
    output logic [7:0] matrix_segout_g
);
    localparam int DW = $clog2(ROW_DWELL);

    logic [DW-1:0]         dwell;
    logic [2:0]            row;
    logic                  disp_sel;
    logic                  pending;
    logic                  swap_hit;
    logic [1:0][7:0][15:0] bank;

    logic        last_dwell;
    logic        boundary;
    logic        blank;
    logic        lit_on;
    logic [15:0] front_row;

    assign last_dwell = (dwell == DW'(ROW_DWELL - 1));
    assign boundary   = last_dwell && (row == 3'd7);
    assign blank      = (32'(dwell) < 32'(BLANK_CYCLES));
    assign front_row  = bank[disp_sel][row];

`ifdef MATRIX_DIM_EN
    localparam int LIT = ROW_DWELL - BLANK_CYCLES;
    logic [2:0]  bright_q;
    logic [2:0]  bright_eff;
    logic [31:0] on_limit;

    // brightness is latched at dwell==0; the live value is used in that same cycle
    always_comb begin
        bright_eff = (dwell == '0) ? brightness : bright_q;
        on_limit   = ((32'(bright_eff) + 32'd1) * 32'(LIT)) >> 3;
        lit_on     = (32'(dwell) - 32'(BLANK_CYCLES)) < on_limit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bright_q <= '0;
        else if (dwell == '0)
            bright_q <= brightness;
    end
`else
    assign lit_on = 1'b1;
`endif

    // scan counters, frame store and swap handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell    <= '0;
            row      <= '0;
            disp_sel <= 1'b0;
            pending  <= 1'b0;
            swap_hit <= 1'b0;
            bank     <= '0;
        end else begin
            if (last_dwell) begin
                dwell <= '0;
                row   <= row + 3'd1;
            end else begin
                dwell <= dwell + DW'(1);
            end

            if (wr_en && !pending)
                bank[~disp_sel][wr_row] <= {wr_r, wr_g};

            swap_hit <= boundary && pending;
            if (boundary && pending) begin
                disp_sel <= ~disp_sel;
                pending  <= 1'b0;
            end else if (swap_req && !pending) begin
                pending <= 1'b1;
            end
        end
    end

    // registered pins, one cycle behind the counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_start     <= 1'b0;
            swap_ack        <= 1'b0;
            wr_drop         <= 1'b0;
            matrix_scanout  <= '0;
            matrix_segout_r <= '0;
            matrix_segout_g <= '0;
        end else begin
            frame_start <= (row == 3'd0) && (dwell == '0);
            swap_ack    <= swap_hit;
            wr_drop     <= wr_en && pending;
            if (blank) begin
                matrix_scanout  <= '0;
                matrix_segout_r <= '0;
                matrix_segout_g <= '0;
            end else begin
                matrix_scanout  <= 8'b1 << row;
                matrix_segout_r <= lit_on ? front_row[15:8] : 8'h00;
                matrix_segout_g <= lit_on ? front_row[7:0]  : 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_matrix_frame_ctrl.sv
// Self-checking bench for matrix_frame_ctrl (ROW_DWELL=16, BLANK_CYCLES=2) against a frame-level model.
module tb_matrix_frame_ctrl;
    localparam int RD = 16;
    localparam int BL = 2;
    localparam int FRAME = 8 * RD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_r = '0;
    logic [7:0] wr_g = '0;
    logic       swap_req = 1'b0;
    logic       swap_ack, wr_drop, frame_start;
    logic [7:0] matrix_scanout, matrix_segout_r, matrix_segout_g;
`ifdef MATRIX_DIM_EN
    logic [2:0] brightness = 3'd7;
`endif

    matrix_frame_ctrl #(.ROW_DWELL(RD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_r(wr_r), .wr_g(wr_g),
        .swap_req(swap_req),
`ifdef MATRIX_DIM_EN
        .brightness(brightness),
`endif
        .swap_ack(swap_ack), .wr_drop(wr_drop), .frame_start(frame_start),
        .matrix_scanout(matrix_scanout), .matrix_segout_r(matrix_segout_r),
        .matrix_segout_g(matrix_segout_g)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // frame-level model: position in frame, two banks, which is shown, pending swap
    bit [15:0] mb [2][8];
    bit        mdisp, mpend, mswapped;
    int        mpos;
    logic [26:0] exp_vec;

    function automatic logic [26:0] act_vec();
        return {frame_start, swap_ack, wr_drop, matrix_scanout, matrix_segout_r, matrix_segout_g};
    endfunction

    task automatic model_reset();
        foreach (mb[b, r]) mb[b][r] = '0;
        mdisp = 0; mpend = 0; mswapped = 0; mpos = 0;
    endtask

    // drive one cycle, predict the outputs it produces, then advance the model
    task automatic step(input bit we, input bit [2:0] wrow, input bit [7:0] dr, input bit [7:0] dg,
                        input bit sreq);
        int rw, dw;
        bit [7:0] e_scan, e_r, e_g;
        wr_en = we; wr_row = wrow; wr_r = dr; wr_g = dg; swap_req = sreq;
        rw = mpos / RD; dw = mpos % RD;
        e_scan = 0; e_r = 0; e_g = 0;
        if (dw >= BL) begin
            e_scan = 8'(1 << rw);
            e_r = mb[mdisp][rw][15:8];
            e_g = mb[mdisp][rw][7:0];
        end
        exp_vec = {(mpos == 0), (mpos == 0) && mswapped, we && mpend, e_scan, e_r, e_g};
        if (mpos == 0) mswapped = 0;
        if (we && !mpend) mb[!mdisp][wrow] = {dr, dg};
        if (mpos == FRAME - 1 && mpend) begin
            mdisp = !mdisp; mpend = 0; mswapped = 1;
        end else if (sreq && !mpend) begin
            mpend = 1;
        end
        mpos = (mpos + 1) % FRAME;
        @(posedge clk); #1;
        wr_en = 0; swap_req = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (act_vec() !== 27'd0) begin
            fails++; $display("FAIL reset_state got %h want 0", act_vec());
        end
        model_reset();
        reset = 1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(0, 0, 0, 0, 0);
            tests++;
            if (act_vec() !== exp_vec) begin
                fails++; $display("FAIL scan_idle pos %0d got %h want %h", (mpos + FRAME - 1) % FRAME, act_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_no_swap();
        for (int r = 0; r < 8; r++) step(1, 3'(r), 8'h81, 8'h3C, 0);
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(0, 0, 0, 0, 0);
            tests++;
            if (act_vec() !== exp_vec || matrix_segout_r !== 8'h00) begin
                fails++; $display("FAIL no_swap_dark got %h want %h", act_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_swap();
        bit seen = 0;
        for (int r = 0; r < 8; r++) step(1, 3'(r), 8'h81, 8'h3C, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            step(0, 0, 0, 0, 0);
            tests++;
            if (act_vec() !== exp_vec) begin
                fails++; $display("FAIL swap_seq got %h want %h", act_vec(), exp_vec);
            end
            if (swap_ack === 1'b1) begin
                seen = 1;
                tests++;
                if (frame_start !== 1'b1) begin
                    fails++; $display("FAIL swap_ack_align frame_start %b want 1", frame_start);
                end
            end
            if (seen && matrix_scanout === 8'h01) begin
                tests++;
                if (matrix_segout_r !== 8'h81 || matrix_segout_g !== 8'h3C) begin
                    fails++; $display("FAIL swap_row0 got r=%h g=%h want 81 3c", matrix_segout_r, matrix_segout_g);
                end
            end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL swap_ack_timeout got none want pulse"); end
    endtask

    task automatic test_drop();
        bit seen = 0;
        while (mpos != 10) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        while (mpos != 20) step(0, 0, 0, 0, 0);
        step(1, 3'd2, 8'hFF, 8'h00, 0);
        tests++;
        if (wr_drop !== 1'b1 || act_vec() !== exp_vec) begin
            fails++; $display("FAIL wr_drop got %b want 1 (vec %h want %h)", wr_drop, act_vec(), exp_vec);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(0, 0, 0, 0, 0);
            tests++;
            if (act_vec() !== exp_vec) begin
                fails++; $display("FAIL drop_seq got %h want %h", act_vec(), exp_vec);
            end
            if (swap_ack === 1'b1) seen = 1;
            if (seen && matrix_scanout === 8'h04) begin
                tests++;
                if (matrix_segout_r === 8'hFF) begin
                    fails++; $display("FAIL drop_row2 got %h want not ff", matrix_segout_r);
                end
            end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL drop_swap_timeout got none want pulse"); end
    endtask

    task automatic test_boundary();
        while (mpos != FRAME - 1) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        tests++;
        if (frame_start !== 1'b1 || swap_ack !== 1'b0) begin
            fails++; $display("FAIL boundary_first got fs=%b ack=%b want 1 0", frame_start, swap_ack);
        end
        for (int i = 0; i < FRAME - 1; i++) begin
            step(0, 0, 0, 0, 0);
            tests++;
            if (act_vec() !== exp_vec) begin
                fails++; $display("FAIL boundary_seq got %h want %h", act_vec(), exp_vec);
            end
        end
        step(0, 0, 0, 0, 0);
        tests++;
        if (frame_start !== 1'b1 || swap_ack !== 1'b1) begin
            fails++; $display("FAIL boundary_next got fs=%b ack=%b want 1 1", frame_start, swap_ack);
        end
    endtask

    task automatic test_reset_mid();
        bit ack_seen = 0;
        while (mpos != 5 * RD) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        while (mpos != 5 * RD + 8) step(0, 0, 0, 0, 0);
        #3 reset = 0;
        #1;
        tests++;
        if (act_vec() !== 27'd0) begin
            fails++; $display("FAIL reset_async got %h want 0", act_vec());
        end
        @(posedge clk); #1;
        model_reset();
        reset = 1;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            step(0, 0, 0, 0, 0);
            tests++;
            if (act_vec() !== exp_vec) begin
                fails++; $display("FAIL reset_mid_seq got %h want %h", act_vec(), exp_vec);
            end
            if (swap_ack === 1'b1 || matrix_segout_r !== 8'h00 || matrix_segout_g !== 8'h00) ack_seen = 1;
        end
        tests++;
        if (ack_seen) begin fails++; $display("FAIL reset_mid_clean got ack/data want none"); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12 * FRAME; i++) begin
            step(bit'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 19) == 0));
            tests++;
            if (act_vec() !== exp_vec) begin
                fails++; $display("FAIL random_seq cycle %0d got %h want %h", i, act_vec(), exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_swap();
        test_swap();
        test_drop();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
